segre_sb_drain: RTL and testbench

Consumer end of the store-buffer flush path: grants the store buffer a flush slot whenever the pipeline is not using the data-cache port, captures the flushed store, and retires it. Data is lane-aligned and byte-enabled before use; a hit writes the data-cache array, a miss goes write-through/no-allocate to memory. Sits between the store buffer, the data-cache tag/data arrays and the memory write port, inside the cache subsystem.

---
 rtl/segre_pkg.sv | 32 +++
 rtl/segre_store_align.sv | 36 +++
 rtl/segre_sb_drain.sv | 122 ++++++++++++
 tb/tb_segre_sb_drain.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared core types: memory-op widths, store-buffer drain FSM states and the drain holding register.
package segre_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [2:0] {
    SB_IDLE   = 3'd0,
    SB_LOOKUP = 3'd1,
    SB_CHECK  = 3'd2,
    SB_WRITE  = 3'd3,
    SB_MEM_WR = 3'd4
  } sb_drain_state_e;

  // Holds a store already lane-aligned, so the write side is a plain register read.
  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
    logic [3:0]           be;
  } sb_hold_t;

  function automatic logic [ADDR_SIZE-1:0] word_align(input logic [ADDR_SIZE-1:0] a);
    return {a[ADDR_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/segre_store_align.sv
// Combinational store alignment: access type + byte offset -> byte enables and lane-placed data.
// valid_o is low for an unrecognised access type; be_o/wdata_o are then zero.
module segre_store_align
  import segre_pkg::*;
(
  input  logic [1:0]           offset_i,
  input  memop_data_type_e     type_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic                 valid_o,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o
);

  always_comb begin
    valid_o = 1'b1;
    be_o    = 4'b0000;
    wdata_o = '0;
    case (type_i)
      BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = WORD_SIZE'(data_i[7:0]) << {offset_i, 3'b000};
      end
      // Halfwords land on the aligned half selected by addr[1]; addr[0] is ignored.
      HALF: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = WORD_SIZE'(data_i[15:0]) << {offset_i[1], 4'b0000};
      end
      WORD: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segre_sb_drain.sv
// Store-buffer drain: takes a flush slot when the cache port is free, looks up the tag, then writes
// the data array on a hit or memory (write-through, no-allocate) on a miss. Optional SEGRE_SB_DRAIN_STATS_EN adds hit/miss counters.
module segre_sb_drain
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 pipe_busy_i,
  output logic                 flush_chance_o,
  input  logic                 sb_data_valid_i,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  memop_data_type_e     sb_memop_data_type_i,
  output logic                 tag_req_o,
  output logic [ADDR_SIZE-1:0] tag_addr_o,
  input  logic                 tag_hit_i,
  output logic                 data_we_o,
  output logic [ADDR_SIZE-1:0] data_addr_o,
  output logic [WORD_SIZE-1:0] data_wdata_o,
  output logic [3:0]           data_be_o,
  output logic                 mem_wr_req_o,
  output logic [ADDR_SIZE-1:0] mem_wr_addr_o,
  output logic [WORD_SIZE-1:0] mem_wr_data_o,
  output logic [3:0]           mem_wr_be_o,
  output logic                 busy_o,
  input  logic                 mem_wr_ack_i
`ifdef SEGRE_SB_DRAIN_STATS_EN
  ,
  output logic [31:0]          stat_hits_o,
  output logic [31:0]          stat_misses_o
`endif
);

  sb_drain_state_e state_q, state_d;
  sb_hold_t        hold_q, hold_d;

  logic                 align_valid;
  logic [3:0]           align_be;
  logic [WORD_SIZE-1:0] align_wdata;

  segre_store_align u_align (
    .offset_i (sb_addr_i[1:0]),
    .type_i   (sb_memop_data_type_i),
    .data_i   (sb_data_i),
    .valid_o  (align_valid),
    .be_o     (align_be),
    .wdata_o  (align_wdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q <= SB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      SB_IDLE: begin
        // An entry with a bad type is still consumed by the grant; it just never leaves IDLE.
        if (!pipe_busy_i && sb_data_valid_i && align_valid) begin
          hold_d.addr  = word_align(sb_addr_i);
          hold_d.wdata = align_wdata;
          hold_d.be    = align_be;
          state_d      = SB_LOOKUP;
        end
      end
      SB_LOOKUP: if (!pipe_busy_i) state_d = SB_CHECK;
      SB_CHECK:  state_d = tag_hit_i ? SB_WRITE : SB_MEM_WR;
      SB_WRITE:  if (!pipe_busy_i) state_d = SB_IDLE;
      SB_MEM_WR: if (mem_wr_ack_i) state_d = SB_IDLE;
      default:   state_d = SB_IDLE;
    endcase
  end

  always_comb begin
    flush_chance_o = rsn_i && (state_q == SB_IDLE) && !pipe_busy_i;
    busy_o         = (state_q != SB_IDLE);

    tag_req_o      = (state_q == SB_LOOKUP) && !pipe_busy_i;
    tag_addr_o     = (state_q == SB_LOOKUP) ? hold_q.addr : '0;

    data_we_o      = (state_q == SB_WRITE) && !pipe_busy_i;
    data_addr_o    = (state_q == SB_WRITE) ? hold_q.addr  : '0;
    data_wdata_o   = (state_q == SB_WRITE) ? hold_q.wdata : '0;
    data_be_o      = (state_q == SB_WRITE) ? hold_q.be    : 4'b0000;

    mem_wr_req_o   = (state_q == SB_MEM_WR);
    mem_wr_addr_o  = (state_q == SB_MEM_WR) ? hold_q.addr  : '0;
    mem_wr_data_o  = (state_q == SB_MEM_WR) ? hold_q.wdata : '0;
    mem_wr_be_o    = (state_q == SB_MEM_WR) ? hold_q.be    : 4'b0000;
  end

`ifdef SEGRE_SB_DRAIN_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (data_we_o && (hits_q != 32'hFFFF_FFFF)) hits_q <= hits_q + 32'd1;
      if (mem_wr_req_o && mem_wr_ack_i && (misses_q != 32'hFFFF_FFFF)) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_segre_sb_drain.sv
// Directed + randomized bench for segre_sb_drain; expected lanes come from a byte-level model.
module tb_segre_sb_drain;
  import segre_pkg::*;

  logic             clk = 1'b0;
  logic             rsn;
  logic             pipe_busy;
  logic             flush_chance;
  logic             sb_valid;
  logic [31:0]      sb_addr;
  logic [31:0]      sb_data;
  memop_data_type_e sb_type;
  logic             tag_req;
  logic [31:0]      tag_addr;
  logic             tag_hit;
  logic             data_we;
  logic [31:0]      data_addr;
  logic [31:0]      data_wdata;
  logic [3:0]       data_be;
  logic             mem_wr_req;
  logic [31:0]      mem_wr_addr;
  logic [31:0]      mem_wr_data;
  logic [3:0]       mem_wr_be;
  logic             mem_wr_ack;
  logic             busy;
`ifdef SEGRE_SB_DRAIN_STATS_EN
  logic [31:0]      stat_hits;
  logic [31:0]      stat_misses;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  always #5 clk = ~clk;

  segre_sb_drain dut (
    .clk_i                (clk),
    .rsn_i                (rsn),
    .pipe_busy_i          (pipe_busy),
    .flush_chance_o       (flush_chance),
    .sb_data_valid_i      (sb_valid),
    .sb_addr_i            (sb_addr),
    .sb_data_i            (sb_data),
    .sb_memop_data_type_i (sb_type),
    .tag_req_o            (tag_req),
    .tag_addr_o           (tag_addr),
    .tag_hit_i            (tag_hit),
    .data_we_o            (data_we),
    .data_addr_o          (data_addr),
    .data_wdata_o         (data_wdata),
    .data_be_o            (data_be),
    .mem_wr_req_o         (mem_wr_req),
    .mem_wr_addr_o        (mem_wr_addr),
    .mem_wr_data_o        (mem_wr_data),
    .mem_wr_be_o          (mem_wr_be),
    .busy_o               (busy),
    .mem_wr_ack_i         (mem_wr_ack)
`ifdef SEGRE_SB_DRAIN_STATS_EN
    ,
    .stat_hits_o          (stat_hits),
    .stat_misses_o        (stat_misses)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Byte-level model: the access covers sz bytes starting at a naturally aligned lane.
  function automatic void ref_lanes(input logic [31:0] a, input logic [31:0] d, input int sz,
                                    output logic [3:0] be, output logic [31:0] wd, output logic [31:0] wa);
    int base;
    base = (sz == 4) ? 0 : (sz == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
    be = 4'b0000;
    wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= base && i < base + sz) begin
        be[i] = 1'b1;
        wd[8*i +: 8] = d[8*(i-base) +: 8];
      end
    end
    wa = a - (a % 4);
  endfunction

  task automatic check_stats();
`ifdef SEGRE_SB_DRAIN_STATS_EN
    chk("stat_hits", stat_hits, exp_hits);
    chk("stat_misses", stat_misses, exp_misses);
`endif
  endtask

  // Grant through LOOKUP and CHECK; leaves the DUT entering WRITE or MEM_WR on return.
  task automatic front_half(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t,
                            input bit hit, input int lk_busy);
    pipe_busy = 1'b0; sb_valid = 1'b1; sb_addr = a; sb_data = d; sb_type = t;
    #1;
    chk("grant", flush_chance, 1);
    chk("grant_idle", busy, 0);
    tick();
    sb_valid = 1'b0; sb_addr = $urandom; sb_data = $urandom;
    for (int k = 0; k < lk_busy; k++) begin
      pipe_busy = 1'b1;
      #1;
      chk("lookup_stall_req", tag_req, 0);
      tick();
    end
    pipe_busy = 1'b0;
    #1;
    chk("tag_req", tag_req, 1);
    chk("tag_addr", tag_addr, a - (a % 4));
    chk("no_grant_busy", flush_chance, 0);
    tick();
    tag_hit = hit;
    #1;
    chk("check_no_req", tag_req, 0);
    tick();
    tag_hit = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t,
                          input bit hit, input int lk_busy, input int wr_busy, input int ack_dly);
    logic [3:0]  be;
    logic [31:0] wd, wa;
    int sz;
    sz = (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
    ref_lanes(a, d, sz, be, wd, wa);
    front_half(a, d, t, hit, lk_busy);
    if (hit) begin
      for (int k = 0; k < wr_busy; k++) begin
        pipe_busy = 1'b1;
        #1;
        chk("write_deferred", data_we, 0);
        tick();
      end
      pipe_busy = 1'b0;
      #1;
      chk("data_we", data_we, 1);
      chk("data_addr", data_addr, wa);
      chk("data_be", data_be, be);
      chk("data_wdata", data_wdata, wd);
      chk("hit_no_memreq", mem_wr_req, 0);
      tick();
      exp_hits++;
    end else begin
      for (int k = 1; k <= ack_dly; k++) begin
        mem_wr_ack = (k == ack_dly);
        pipe_busy = 1'($urandom);
        #1;
        chk("mem_wr_req", mem_wr_req, 1);
        chk("mem_wr_addr", mem_wr_addr, wa);
        chk("mem_wr_be", mem_wr_be, be);
        chk("mem_wr_data", mem_wr_data, wd);
        chk("miss_no_we", data_we, 0);
        tick();
      end
      mem_wr_ack = 1'b0;
      exp_misses++;
    end
    pipe_busy = 1'b0;
    #1;
    chk("back_idle", busy, 0);
    chk("regrant", flush_chance, 1);
    chk("idle_no_memreq", mem_wr_req, 0);
  endtask

  initial begin
    rsn = 1'b0; pipe_busy = 1'b0; sb_valid = 1'b0; sb_addr = '0; sb_data = '0;
    sb_type = WORD; tag_hit = 1'b0; mem_wr_ack = 1'b0;

    // Reset: flush slot withheld while reset is low, all outputs zero afterwards.
    tick();
    #1;
    chk("rst_flush_chance", flush_chance, 0);
    tick();
    rsn = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tag_req", tag_req, 0);
    chk("rst_tag_addr", tag_addr, 0);
    chk("rst_data_we", data_we, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_mem_wr_req", mem_wr_req, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_be", {28'h0, mem_wr_be}, 0);
    check_stats();

    do_store(32'h0000_0100, 32'hDEAD_BEEF, WORD, 1'b1, 0, 0, 0);
    do_store(32'h0000_0203, 32'h0000_00A5, BYTE, 1'b1, 0, 0, 0);
    chk("byte_lane_ref", data_wdata, 32'h0);
    do_store(32'h0000_0302, 32'h0000_1234, HALF, 1'b0, 0, 0, 5);
    do_store(32'h0000_0404, 32'hCAFE_F00D, WORD, 1'b1, 0, 3, 0);
    check_stats();

    // Pipeline owns the port in IDLE: no grant, entry not taken.
    pipe_busy = 1'b1; sb_valid = 1'b1; sb_addr = 32'h500; sb_type = WORD;
    #1;
    chk("idle_busy_no_grant", flush_chance, 0);
    tick();
    pipe_busy = 1'b0; sb_valid = 1'b0;
    #1;
    chk("idle_busy_not_taken", busy, 0);

    // Unknown access type is dropped in IDLE.
    sb_valid = 1'b1; sb_type = memop_data_type_e'(2'b11);
    #1;
    chk("bad_type_grant", flush_chance, 1);
    tick();
    sb_valid = 1'b0; sb_type = WORD;
    #1;
    chk("bad_type_idle", busy, 0);
    chk("bad_type_no_req", tag_req, 0);

    // Reset while a miss is waiting for its ack.
    front_half(32'h0000_0600, 32'h1111_2222, WORD, 1'b0, 0);
    #1;
    chk("pre_rst_memreq", mem_wr_req, 1);
    tick();
    rsn = 1'b0;
    tick();
    rsn = 1'b1;
    exp_hits = 0; exp_misses = 0;
    #1;
    chk("post_rst_memreq", mem_wr_req, 0);
    chk("post_rst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("post_rst_quiet", {29'h0, mem_wr_req, data_we, tag_req}, 0);
    end
    check_stats();

    do_store(32'h0000_0700, 32'h0102_0304, WORD, 1'b1, 0, 0, 0);
    do_store(32'h0000_0801, 32'h0000_0077, BYTE, 1'b1, 1, 1, 0);
    do_store(32'h0000_0900, 32'h0000_BEEF, HALF, 1'b0, 0, 0, 1);
    check_stats();

    for (int n = 0; n < 25; n++) begin
      do_store($urandom, $urandom, memop_data_type_e'($urandom_range(0, 2)), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 4));
      tick();
    end
    check_stats();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
